// File: rtl/alu.sv
// Registered signed ALU (ADD/SUB/AND/OR) with carry, overflow, zero and negative flags; 1-cycle latency.
// Optional clamping of overflowing ADD/SUB results is enabled by defining ALU_SAT_EN.
module alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       ctrl,
  output logic [WIDTH-1:0] Z,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_t;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {MSB{1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {MSB{1'b0}}};

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] z_next;
  logic             carry_next;
  logic             ovf_next;

  // Zero-extended arithmetic: bit WIDTH is the carry for ADD and the borrow for SUB.
  assign sum_ext  = {1'b0, A} + {1'b0, B};
  assign diff_ext = {1'b0, A} - {1'b0, B};

  always_comb begin
    z_next     = '0;
    carry_next = 1'b0;
    ovf_next   = 1'b0;
    case (op_t'(ctrl))
      OP_ADD: begin
        z_next     = sum_ext[MSB:0];
        carry_next = sum_ext[WIDTH];
        ovf_next   = (A[MSB] == B[MSB]) && (sum_ext[MSB] != A[MSB]);
      end
      OP_SUB: begin
        z_next     = diff_ext[MSB:0];
        carry_next = diff_ext[WIDTH];
        ovf_next   = (A[MSB] != B[MSB]) && (diff_ext[MSB] != A[MSB]);
      end
      OP_AND: z_next = A & B;
      OP_OR:  z_next = A | B;
    endcase
`ifdef ALU_SAT_EN
    // On overflow the true result always has the sign of A, for both ADD and SUB.
    if (ovf_next) begin
      z_next = A[MSB] ? MIN_NEG : MAX_POS;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Z     <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
      neg   <= 1'b0;
    end else begin
      Z     <= z_next;
      carry <= carry_next;
      ovf   <= ovf_next;
      zero  <= (z_next == '0);
      neg   <= z_next[MSB];
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed spec vectors, randomized ops against an integer-arithmetic model,
// and an asynchronous mid-cycle reset. Honours ALU_SAT_EN in the model.
module tb_alu;

  localparam int W = 4;
`ifdef ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [1:0]   ctrl;
  logic [W-1:0] Z;
  logic         carry;
  logic         ovf;
  logic         zero;
  logic         neg;

  int checks_total  = 0;
  int checks_passed = 0;

  alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .ctrl  (ctrl),
    .Z     (Z),
    .carry (carry),
    .ovf   (ovf),
    .zero  (zero),
    .neg   (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: interpret operands as integers, compute the true result, then reduce to W bits.
  // Returns {Z, carry, ovf, zero, neg}.
  function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] op);
    int sa, sb, ua, ub, t, maxp, minn;
    logic [W-1:0] z;
    logic c, o;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    maxp = (1 << (W - 1)) - 1;
    minn = -(1 << (W - 1));
    c = 1'b0;
    o = 1'b0;
    t = 0;
    case (op)
      2'd0: begin t = sa + sb; c = (ua + ub) >= (1 << W); end
      2'd1: begin t = sa - sb; c = ua < ub; end
      2'd2: t = int'(a & b);
      default: t = int'(a | b);
    endcase
    if (op < 2) o = (t > maxp) || (t < minn);
    z = t[W-1:0];
    if (SAT && o) z = (t > 0) ? maxp[W-1:0] : minn[W-1:0];
    return {z, c, o, (z == '0), z[W-1]};
  endfunction

  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    logic [W+3:0] exp;
    A = a; B = b; ctrl = op;
    exp = model(a, b, op);
    @(posedge clk);
    #1;
    $display("op=%0d A=%h B=%h -> Z=%h c=%b v=%b zr=%b n=%b (exp Z=%h c=%b v=%b zr=%b n=%b)",
             op, a, b, Z, carry, ovf, zero, neg,
             exp[W+3:4], exp[3], exp[2], exp[1], exp[0]);
    check("Z", 32'(Z), 32'(exp[W+3:4]));
    check("flags", 32'({carry, ovf, zero, neg}), 32'(exp[3:0]));
  endtask

  initial begin
    rst = 1'b1; A = '0; B = '0; ctrl = 2'd0;
    #1;
    check("reset_Z", 32'(Z), 32'd0);
    check("reset_flags", 32'({carry, ovf, zero, neg}), 32'd0);
    @(posedge clk);
    #1;
    check("reset_hold_flags", 32'({carry, ovf, zero, neg}), 32'd0);
    rst = 1'b0;

    // Directed vectors, back-to-back
    apply(4'b0011, 4'b0010, 2'd0);
    apply(4'b0111, 4'b0001, 2'd0);
    apply(4'b0010, 4'b0101, 2'd1);
    apply(4'b0110, 4'b0110, 2'd1);
    apply(4'b1100, 4'b1010, 2'd2);
    apply(4'b1100, 4'b1010, 2'd3);
    apply(4'b1000, 4'b1000, 2'd0);
    apply(4'b1000, 4'b0001, 2'd1);
    apply(4'b0111, 4'b1111, 2'd1);
    apply(4'b1111, 4'b0001, 2'd0);

    for (int i = 0; i < 200; i++) begin
      apply(W'($urandom), W'($urandom), 2'($urandom_range(0, 3)));
    end

    // Asynchronous mid-cycle reset discards the pending result
    apply(4'b0011, 4'b0010, 2'd0);
    A = 4'b0101; B = 4'b0001; ctrl = 2'd3;
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_Z", 32'(Z), 32'd0);
    check("async_rst_flags", 32'({carry, ovf, zero, neg}), 32'd0);
    @(posedge clk);
    #1;
    check("rst_held_Z", 32'(Z), 32'd0);
    check("rst_held_flags", 32'({carry, ovf, zero, neg}), 32'd0);
    rst = 1'b0;
    apply(4'b0101, 4'b0001, 2'd3);
    apply(4'b0100, 4'b0100, 2'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
